mem_slave: RTL
==============

MEM_SLAVE -- requirements
Module: mem_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h80000000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096: number of 32-bit words stored.
REQ-003 SHALL have parameter LATENCY, default 2: extra wait cycles between request acceptance and response.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  slave can accept a request.
REQ-008 SHALL have port req_wen  in  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  write data, byte lanes aligned to the word.
REQ-011 SHALL have port req_wmask  in  4  byte-enable mask; bit i enables wdata[8i+7:8i].
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  initiator accepts the response.
REQ-014 SHALL have port rsp_rdata  out  32  read data (full word); 0 for writes and errors.
REQ-015 SHALL have port rsp_err  out  1  address was out of range or misaligned.

Function
REQ-016 SHALL implement states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid & req_ready.
REQ-018 SHALL, on acceptance, latch wen/addr/wdata/wmask and go to WAIT with counter=LATENCY, or directly to RESP when LATENCY==0.
REQ-019 SHALL decrement the counter once per cycle in WAIT and go to RESP on the edge where the counter is 1.
REQ-020 SHALL assert rsp_valid exactly LATENCY+1 cycles after the acceptance edge and hold rsp_valid, rsp_rdata and rsp_err stable until rsp_valid & rsp_ready.
REQ-021 SHALL return to IDLE on the response-handshake edge, giving a minimum of LATENCY+2 cycles per transaction; there is no overlap of requests.
REQ-022 SHALL compute index = (addr-BASE_ADDR)>>2 and flag an error when addr<BASE_ADDR, index>=DEPTH_WORDS, or addr[1:0]!=0.
REQ-023 SHALL commit a write on the acceptance edge, updating only the bytes enabled by wmask; wmask=0 leaves memory unchanged but still produces a response.
REQ-024 SHALL sample read data on the edge entering RESP, so a read returns the value after any earlier write.
REQ-025 SHALL suppress the memory update for an erroring write and return rsp_rdata=0 with rsp_err=1.
REQ-026 SHALL drop a rsp_ready that arrives while rsp_valid=0 with no effect.
REQ-027 SHALL ignore req_valid outside IDLE; the initiator holds the request until it sees req_ready.

Reset
REQ-028 SHALL, when reset=0 at a posedge, enter IDLE with req_ready=1 after that edge, rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0.
REQ-029 SHALL, on reset mid-transaction (WAIT or RESP), abandon the transaction silently; a write already committed stays committed.
REQ-030 SHALL NOT reset the memory array contents.

Configuration
REQ-031 SHALL, with MEM_SLAVE_RAND_DELAY_EN defined, add a pseudo-random 0..3 extra wait cycles to each transaction, taken from lfsr[1:0] at acceptance.
REQ-032 SHALL use an 8-bit LFSR (x^8+x^6+x^5+x^4+1) seeded with 8'hA5 on reset that advances every cycle.
REQ-033 SHALL, without MEM_SLAVE_RAND_DELAY_EN, have a fixed latency of exactly LATENCY with no LFSR logic.

Structure
REQ-034 SHALL place the state enum (IDLE/WAIT/RESP), the default BASE_ADDR and the LFSR seed constant in the shared package mem_slave_pkg.
REQ-035 SHALL implement the LFSR as sub-module lfsr8, instantiated only under MEM_SLAVE_RAND_DELAY_EN.

Verification
REQ-036 Write 0xDEADBEEF, mask 4'hF, to 0x80000010, then read the same address -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 3 cycles after acceptance (LATENCY=2).
REQ-037 Write 0x000000AA, mask 4'b0001, over word 0x11223344 at 0x80000020, then read -> 0x112233AA.
REQ-038 Read 0x80000002 and read 0x80004000 (DEPTH_WORDS=4096) -> each gives rsp_err=1, rsp_rdata=0; a write to the out-of-range address leaves the following read of 0x80000000 unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stay stable and req_ready=0 throughout; req_ready=1 the cycle after the handshake.
REQ-040 Assert reset=0 during WAIT of a read -> rsp_valid never asserts and req_ready=1 after the reset edge; memory contents are unchanged.
REQ-041 With LATENCY=0, issue back-to-back reads with rsp_ready tied to 1 -> each rsp_valid 1 cycle after acceptance, one transaction every 2 cycles.

Source files
------------

// File: rtl/mem_slave_pkg.sv
// Shared types and constants for the mem_slave memory model: FSM states, default base
// address and the seed of the optional delay LFSR.
package mem_slave_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam logic [31:0] DefaultBaseAddr = 32'h8000_0000;
    localparam logic [7:0]  LfsrSeed        = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, reloads SEED on reset and
// advances every cycle.
module lfsr8
    import mem_slave_pkg::*;
#(
    parameter logic [7:0] SEED = LfsrSeed
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= SEED;
        end else begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/mem_slave.sv
// Word-organised memory slave with valid/ready request and response channels.
// Optional feature macro: MEM_SLAVE_RAND_DELAY_EN adds 0..3 pseudo-random wait cycles.
module mem_slave
    import mem_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q;
    logic [7:0]      start_lat;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [IdxW-1:0] idx_q, cur_idx;
    logic            wen_q, err_q, cur_wen, cur_err;
    logic [31:0]     rdata_q;
    logic            rsp_err_q;
    logic [31:0]     word_off;
    logic            req_err;
    logic            accept;

    assign word_off = (req_addr - BASE_ADDR) >> 2;
    assign req_err  = (req_addr < BASE_ADDR) || (req_addr[1:0] != 2'b00) ||
                      (word_off >= DEPTH_WORDS);
    assign accept   = req_valid && req_ready;

`ifdef MEM_SLAVE_RAND_DELAY_EN
    logic [7:0] lfsr_value;

    lfsr8 #(
        .SEED (LfsrSeed)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    assign start_lat = 8'(LATENCY) + {6'd0, lfsr_value[1:0]};
`else
    assign start_lat = 8'(LATENCY);
`endif

    // With zero latency RESP is entered on the acceptance edge, before the latches are valid.
    always_comb begin
        if (state_q == StIdle) begin
            cur_idx = word_off[IdxW-1:0];
            cur_wen = req_wen;
            cur_err = req_err;
        end else begin
            cur_idx = idx_q;
            cur_wen = wen_q;
            cur_err = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = (start_lat == 8'd0) ? StResp : StWait;
            StWait:  if (cnt_q <= 8'd1) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_rdata = rdata_q;
        rsp_err   = rsp_err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= 8'd0;
            idx_q     <= '0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= start_lat;
                idx_q <= word_off[IdxW-1:0];
                wen_q <= req_wen;
                err_q <= req_err;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (state_d == StResp && state_q != StResp) begin
                rdata_q   <= (cur_wen || cur_err) ? 32'd0 : mem[cur_idx];
                rsp_err_q <= cur_err;
            end
        end
    end

    // Array is deliberately not reset; writes commit on the acceptance edge.
    always_ff @(posedge clk) begin
        if (reset && accept && req_wen && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wmask[b]) begin
                    mem[word_off[IdxW-1:0]][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
